int_entry_seq: RTL

//  Interrupt/BRK entry sequencer for the 6502 core. Consumes the prioritised
//  rst/nmi/irq requests from the interrupt sequencer, plus BRK from decode, and

---
 rtl/int_entry_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/int_entry_seq.sv
// 6502 interrupt/BRK entry sequencer: dummy read, push PCH/PCL/P, fetch vector.
// Owns the bus for six cycles, then hands the vector target to fetch with done.
module int_entry_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        brk,
  input  logic        rst,
  input  logic        nmi,
  input  logic        irq,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  output logic        sp_dec,
  output logic        set_i,
  output logic        busy,
  output logic        nmi_ack,
  output logic        done,
  output logic [15:0] new_pc
);

  // state | meaning
  // IDLE  | bus released, waiting for start with a pending source
  // T1    | dummy read at pc
  // T2    | push PCH (read for reset)
  // T3    | push PCL (read for reset)
  // T4    | push P with B=brk (read for reset)
  // T5    | read vector low byte, set I
  // T6    | read vector high byte; done follows
  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4, T5, T6} state_t;
  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  state_t      state;
  src_t        src_q;
  logic        use_nmi_q;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [7:0]  sp_q;
  logic [7:0]  vec_lo_q;

  logic        is_rst;
  logic        nmi_hit;
  logic        use_nmi_nx;
  logic [15:0] vec;
  logic [7:0]  p_push;

  always_comb begin
    is_rst     = (src_q == SRC_RST);
    // an NMI seen up to the end of T4 still steers an irq/brk entry
    nmi_hit    = nmi && (state inside {T1, T2, T3, T4}) &&
                 (src_q == SRC_IRQ || src_q == SRC_BRK);
    use_nmi_nx = use_nmi_q || nmi_hit;
    vec        = is_rst ? VEC_RST : (use_nmi_nx ? VEC_NMI : VEC_IRQ);
    p_push     = {p_q[7:6], 1'b1, (src_q == SRC_BRK), p_q[3:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= SRC_IRQ;
      use_nmi_q <= 1'b0;
      pc_q      <= '0;
      p_q       <= '0;
      sp_q      <= '0;
      vec_lo_q  <= '0;
      addr      <= '0;
      dout      <= '0;
      we        <= 1'b0;
      sp_dec    <= 1'b0;
      set_i     <= 1'b0;
      busy      <= 1'b0;
      nmi_ack   <= 1'b0;
      done      <= 1'b0;
      new_pc    <= '0;
    end else begin
      we      <= 1'b0;
      sp_dec  <= 1'b0;
      set_i   <= 1'b0;
      nmi_ack <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (rst || nmi || irq || brk)) begin
            state     <= T1;
            src_q     <= rst ? SRC_RST : nmi ? SRC_NMI : irq ? SRC_IRQ : SRC_BRK;
            use_nmi_q <= !rst && nmi;
            pc_q      <= pc;
            p_q       <= p;
            sp_q      <= sp;
            addr      <= pc;
            busy      <= 1'b1;
          end
        end
        T1: begin
          state     <= T2;
          use_nmi_q <= use_nmi_nx;
          addr      <= {STACK_PAGE, sp_q};
          dout      <= pc_q[15:8];
          we        <= !is_rst;
          sp_dec    <= 1'b1;
        end
        T2: begin
          state     <= T3;
          use_nmi_q <= use_nmi_nx;
          addr      <= {STACK_PAGE, sp_q - 8'd1};
          dout      <= pc_q[7:0];
          we        <= !is_rst;
          sp_dec    <= 1'b1;
        end
        T3: begin
          state     <= T4;
          use_nmi_q <= use_nmi_nx;
          addr      <= {STACK_PAGE, sp_q - 8'd2};
          dout      <= p_push;
          we        <= !is_rst;
          sp_dec    <= 1'b1;
        end
        T4: begin
          state     <= T5;
          use_nmi_q <= use_nmi_nx;
          addr      <= vec;
          set_i     <= 1'b1;
        end
        T5: begin
          state    <= T6;
          addr     <= vec + 16'd1;
          vec_lo_q <= din;
        end
        T6: begin
          state   <= IDLE;
          new_pc  <= {din, vec_lo_q};
          done    <= 1'b1;
          nmi_ack <= use_nmi_q;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
